natalius_mem_arbiter: RTL

- Shares the single-port 16-bit OpenRAM-style SRAM of the Natalius SoC between two requesters: the management Wishbone slave port and the Natalius CPU data port.
- Arbitrates round-robin, sequences each SRAM access through a fixed 4-state FSM, and returns read data plus a Wishbone ack or a CPU read-valid.
- Sits inside natalius_soc, between the Wishbone pins and the SRAM macro.

---
 rtl/natalius_pkg.sv | 20 ++
 rtl/natalius_rr_arb2.sv | 35 +++
 rtl/natalius_mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/natalius_pkg.sv
// Shared types and defaults for the Natalius SRAM arbiter.
// Covers the access FSM states, the requester identity and the Wishbone decode window.
package natalius_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_WB  = 1'b1
  } req_t;

  localparam logic [31:0] WB_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] WB_MASK_DEF = 32'hFFFF_F000;

endpackage

// File: rtl/natalius_rr_arb2.sv
// Two-requester round-robin arbiter (CPU vs Wishbone).
// The pointer remembers the last winner, so under contention the other side wins next.
module natalius_rr_arb2
  import natalius_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_cpu,
  input  logic req_wb,
  input  logic take,
  output logic win_wb
);

  req_t last;
  req_t win;

  always_comb begin
    win = REQ_CPU;
    if (req_cpu && req_wb)
      win = (last == REQ_CPU) ? REQ_WB : REQ_CPU;
    else if (req_wb)
      win = REQ_WB;
  end

  assign win_wb = (win == REQ_WB);

  // Reset value of "last = WB" makes the CPU the first winner under contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= REQ_WB;
    else if (take && (req_cpu || req_wb))
      last <= win;
  end

endmodule

// File: rtl/natalius_mem_arbiter.sv
// Shares the single-port SRAM between the Wishbone slave port and the CPU data port.
// Each access runs IDLE -> MEM -> CAPT -> RESP; all outputs are registered.
module natalius_mem_arbiter
  import natalius_pkg::*;
#(
  parameter int          AW      = 8,
  parameter int          DW      = 16,
  parameter logic [31:0] WB_BASE = WB_BASE_DEF,
  parameter logic [31:0] WB_MASK = WB_MASK_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [1:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [DW-1:0] wbs_dat_o,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          sram_csb,
  output logic          sram_web,
  output logic [1:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  state_t        state;
  req_t          owner;
  logic          acc_we;
  logic          wb_req;
  logic          win_wb;
  logic [AW-1:0] wb_word;

  assign wb_req  = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & WB_MASK) == WB_BASE);
  assign wb_word = wbs_adr_i[AW+1:2];

  natalius_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_cpu (cpu_req),
    .req_wb  (wb_req),
    .take    (state == IDLE),
    .win_wb  (win_wb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_CPU;
      acc_we     <= 1'b0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req || cpu_req) begin
            sram_csb <= 1'b0;
            state    <= MEM;
            if (win_wb) begin
              owner      <= REQ_WB;
              acc_we     <= wbs_we_i;
              sram_web   <= ~wbs_we_i;
              sram_wmask <= wbs_we_i ? wbs_sel_i : 2'b00;
              sram_addr  <= wb_word;
              sram_din   <= wbs_dat_i;
            end else begin
              owner      <= REQ_CPU;
              acc_we     <= cpu_we;
              sram_web   <= ~cpu_we;
              sram_wmask <= cpu_we ? 2'b11 : 2'b00;
              sram_addr  <= cpu_addr;
              sram_din   <= cpu_wdata;
              cpu_gnt    <= 1'b1;
            end
          end
        end
        MEM: begin
          sram_csb   <= 1'b1;
          sram_web   <= 1'b1;
          sram_wmask <= 2'b00;
          cpu_gnt    <= 1'b0;
          state      <= CAPT;
        end
        CAPT: begin
          // sram_dout is valid now, one cycle after the chip-select cycle.
          if (!acc_we) begin
            if (owner == REQ_WB) wbs_dat_o <= sram_dout;
            else                 cpu_rdata <= sram_dout;
          end
          // An abandoned Wishbone cycle gets no ack.
          wbs_ack_o  <= (owner == REQ_WB) && wbs_cyc_i;
          cpu_rvalid <= (owner == REQ_CPU) && !acc_we;
          state      <= RESP;
        end
        RESP: begin
          wbs_ack_o  <= 1'b0;
          cpu_rvalid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
